// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-access transaction controller:
// FSM state encoding and command-frame constants.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_DONE,
    POP,
    CAPTURE,
    FINISH,
    ABORT
  } state_t;

  // Byte 0 of every frame is {rw, addr[6:0]}.
  localparam int         RW_BIT   = 7;
  localparam logic [7:0] RD_DUMMY = 8'h00;

endpackage

// File: rtl/spi_txn_timeout.sv
// Saturating wait counter: counts enabled cycles since the last clear and
// flags expiry on the LIMIT-th enabled cycle; it never wraps.
module spi_txn_timeout #(
  parameter int CNT_W = 13,
  parameter int LIMIT = 4096
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expired_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q < LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry is seen during the LIMIT-th waiting cycle so the FSM leaves on
  // exactly that edge.
  assign expired_o = (cnt_q >= LAST);

endmodule

// File: rtl/spi_txn_ctrl.sv
// Register-access transaction controller in front of spi_master: serialises
// one {rw,addr}+data frame byte by byte and drains the matching RX bytes.
module spi_txn_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_BYTES     = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 13
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic                    i_rw,
  input  logic [6:0]              i_addr,
  input  logic [8*DATA_BYTES-1:0] i_wdata,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_error,
  output logic [8*DATA_BYTES-1:0] o_rdata,
  output logic                    o_DV,
  output logic [7:0]              o_tx_byte,
  input  logic                    i_byte_done,
  output logic                    o_read_enable,
  input  logic [7:0]              i_rx_byte,
  input  logic                    i_rx_empty,
  input  logic                    i_rst_busy
);

  localparam int               W        = 8 * DATA_BYTES;
  localparam int               IDX_W    = $clog2(DATA_BYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BYTES);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             rw_q, rw_d;
  logic [6:0]       addr_q, addr_d;
  logic [W-1:0]     wdata_q, wdata_d;
  logic [W-1:0]     rdata_q, rdata_d;
  logic             tmr_clr, tmr_en, tmr_expired;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    rw_d          = rw_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    o_busy        = 1'b0;
    o_done        = 1'b0;
    o_error       = 1'b0;
    o_DV          = 1'b0;
    o_tx_byte     = '0;
    o_read_enable = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start && !i_rst_busy) begin
          rw_d    = i_rw;
          addr_d  = i_addr;
          wdata_d = i_wdata;
          idx_d   = '0;
          state_d = SEND;
        end
      end

      SEND: begin
        o_busy = 1'b1;
        o_DV   = 1'b1;
        if (idx_q == '0) begin
          o_tx_byte[RW_BIT]     = rw_q;
          o_tx_byte[RW_BIT-1:0] = addr_q;
        end else if (rw_q) begin
          o_tx_byte = RD_DUMMY;
        end else begin
          // Write data leaves MSB byte first; shift so the next byte is on top.
          o_tx_byte = wdata_q[W-1 -: 8];
          wdata_d   = wdata_q << 8;
        end
        state_d = WAIT_DONE;
      end

      WAIT_DONE: begin
        o_busy = 1'b1;
        if (i_byte_done) begin
          state_d = POP;
        end else if (tmr_expired) begin
          state_d = ABORT;
        end
      end

      POP: begin
        o_busy = 1'b1;
        if (!i_rx_empty) begin
          o_read_enable = 1'b1;
          state_d       = CAPTURE;
        end else if (tmr_expired) begin
          state_d = ABORT;
        end
      end

      CAPTURE: begin
        o_busy = 1'b1;
        // The response to the command byte carries no data.
        if (rw_q && (idx_q != '0)) begin
          rdata_d = (rdata_q << 8) | W'(i_rx_byte);
        end
        if (idx_q == LAST_IDX) begin
          state_d = FINISH;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = SEND;
        end
      end

      FINISH: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end

      ABORT: begin
        o_error = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge i_clk) begin
    rw_q    <= rw_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign tmr_clr = (state_d != state_q);
  assign tmr_en  = (state_q == WAIT_DONE) || (state_q == POP);

  spi_txn_timeout #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i      (i_clk),
    .rst_i      (i_reset),
    .clr_i      (tmr_clr),
    .en_i       (tmr_en),
    .load_i     (1'b0),
    .load_val_i ('0),
    .expired_o  (tmr_expired)
  );

  assign o_rdata = rdata_q;

endmodule

// File: tb/tb_spi_txn_ctrl.sv
// Self-checking bench for spi_txn_ctrl with a behavioural spi_master stand-in
// (random byte latency, RX FIFO queue) and a frame-level reference model.
module tb_spi_txn_ctrl;

  localparam int DATA_BYTES     = 4;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int CNT_W          = 5;
  localparam int W              = 8 * DATA_BYTES;
  localparam int N              = DATA_BYTES + 1;

  logic         i_clk = 1'b0;
  logic         i_reset, i_start, i_rw;
  logic [6:0]   i_addr;
  logic [W-1:0] i_wdata;
  logic         o_busy, o_done, o_error;
  logic [W-1:0] o_rdata;
  logic         o_DV;
  logic [7:0]   o_tx_byte;
  logic         i_byte_done;
  logic         o_read_enable;
  logic [7:0]   i_rx_byte;
  logic         i_rx_empty;
  logic         i_rst_busy;

  spi_txn_ctrl #(
    .DATA_BYTES     (DATA_BYTES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_rw          (i_rw),
    .i_addr        (i_addr),
    .i_wdata       (i_wdata),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_error       (o_error),
    .o_rdata       (o_rdata),
    .o_DV          (o_DV),
    .o_tx_byte     (o_tx_byte),
    .i_byte_done   (i_byte_done),
    .o_read_enable (o_read_enable),
    .i_rx_byte     (i_rx_byte),
    .i_rx_empty    (i_rx_empty),
    .i_rst_busy    (i_rst_busy)
  );

  initial forever #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // spi_master stand-in and observation state
  logic [7:0]   rxq[$];
  logic [7:0]   txlog[$];
  logic [7:0]   resp[N];
  int           resp_idx, bd_cnt, rx_cnt, rx_delay, lat_max, viol;
  bit           stall;
  int           cyc, dv_cnt, rd_cnt, done_cnt, err_cnt, dv_cyc, err_cyc;
  logic         obs_dv, obs_re, obs_done, obs_err, obs_busy;
  logic [7:0]   obs_tx;
  logic [W-1:0] obs_rdata, rdata_at_done, model_rdata;
  logic         busy_at_done, busy_at_err;

  task automatic flush();
    rxq.delete();
    bd_cnt      = 0;
    rx_cnt      = 0;
    resp_idx    = 0;
    viol        = 0;
    i_byte_done = 1'b0;
    i_rx_empty  = 1'b1;
  endtask

  task automatic clear_log();
    txlog.delete();
    dv_cnt   = 0;
    rd_cnt   = 0;
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  // One clock: observe DUT outputs mid-cycle, then update the stand-in's
  // inputs just after the next rising edge.
  task automatic tick();
    @(negedge i_clk);
    cyc++;
    obs_dv    = o_DV;
    obs_tx    = o_tx_byte;
    obs_re    = o_read_enable;
    obs_done  = o_done;
    obs_err   = o_error;
    obs_busy  = o_busy;
    obs_rdata = o_rdata;
    if (obs_done) begin
      done_cnt++;
      busy_at_done  = obs_busy;
      rdata_at_done = obs_rdata;
    end
    if (obs_err) begin
      err_cnt++;
      err_cyc     = cyc;
      busy_at_err = obs_busy;
    end
    if (obs_re) rd_cnt++;
    @(posedge i_clk);
    #1;
    i_byte_done = 1'b0;
    if (obs_re) begin
      if (rxq.size() == 0) begin
        viol++;
        i_rx_byte = 8'h00;
      end else begin
        i_rx_byte = rxq.pop_front();
      end
    end
    if (bd_cnt > 0) begin
      bd_cnt--;
      if (bd_cnt == 0 && !stall) begin
        i_byte_done = 1'b1;
        rx_cnt      = rx_delay + 1;
      end
    end
    if (rx_cnt > 0) begin
      rx_cnt--;
      if (rx_cnt == 0) begin
        rxq.push_back(resp[resp_idx]);
        if (resp_idx < N - 1) resp_idx++;
      end
    end
    if (obs_dv) begin
      txlog.push_back(obs_tx);
      dv_cnt++;
      dv_cyc = cyc;
      if (bd_cnt != 0) viol++;
      bd_cnt = $urandom_range(lat_max, 1);
    end
    i_rx_empty = (rxq.size() == 0);
  endtask

  // One complete transaction checked against the frame-level model.
  task automatic run_txn(input logic rw, input logic [6:0] addr, input logic [W-1:0] wd,
                         input logic [W-1:0] rresp, input int rxd, input bit poke);
    logic [7:0]   exp_frame[N];
    logic [W-1:0] exp_rd, tmp;
    int           n;
    exp_frame[0] = {rw, addr};
    for (int k = 1; k < N; k++) begin
      tmp          = wd >> (8 * (DATA_BYTES - k));
      exp_frame[k] = rw ? 8'h00 : tmp[7:0];
    end
    exp_rd = rw ? rresp : model_rdata;

    flush();
    clear_log();
    rx_delay = rxd;
    resp[0]  = 8'($urandom);
    for (int k = 1; k < N; k++) begin
      tmp     = rresp >> (8 * (DATA_BYTES - k));
      resp[k] = tmp[7:0];
    end

    i_rw = rw; i_addr = addr; i_wdata = wd; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_rw = ~rw; i_addr = ~addr; i_wdata = ~wd;
    tick();
    chk("busy_after_start", 64'(obs_busy), 64'd1);

    n = 0;
    while (done_cnt == 0 && err_cnt == 0 && n < 400) begin
      i_start    = poke && (n == 6);
      i_rst_busy = poke && (n >= 9) && (n < 12);
      tick();
      n++;
    end
    i_start    = 1'b0;
    i_rst_busy = 1'b0;
    if (n >= 400) chk("txn_bound", 64'd0, 64'd1);
    tick();
    tick();

    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("err_pulses", 64'(err_cnt), 64'd0);
    chk("busy_at_done", 64'(busy_at_done), 64'd0);
    chk("busy_after_done", 64'(obs_busy), 64'd0);
    chk("dv_count", 64'(dv_cnt), 64'(N));
    chk("rd_en_count", 64'(rd_cnt), 64'(N));
    chk("protocol", 64'(viol), 64'd0);
    for (int k = 0; k < N; k++) begin
      if (k < txlog.size()) chk($sformatf("tx_byte%0d", k), 64'(txlog[k]), 64'(exp_frame[k]));
    end
    chk("rdata_at_done", 64'(rdata_at_done), 64'(exp_rd));
    chk("rdata_hold", 64'(obs_rdata), 64'(exp_rd));
    model_rdata = exp_rd;
  endtask

  initial begin
    int n;
    i_reset = 1'b1; i_start = 1'b0; i_rw = 1'b0; i_addr = '0; i_wdata = '0;
    i_byte_done = 1'b0; i_rx_byte = '0; i_rx_empty = 1'b1; i_rst_busy = 1'b0;
    stall = 1'b0; lat_max = 4; rx_delay = 0; model_rdata = '0; cyc = 0;
    flush();
    clear_log();

    tick();
    tick();
    chk("rst_busy", 64'(obs_busy), 64'd0);
    chk("rst_dv", 64'(obs_dv), 64'd0);
    chk("rst_done", 64'(obs_done), 64'd0);
    chk("rst_err", 64'(obs_err), 64'd0);
    chk("rst_rdata", 64'(obs_rdata), 64'd0);
    i_reset = 1'b0;
    tick();

    run_txn(1'b0, 7'h12, 32'hDEADBEEF, 32'h0BAD_F00D, 0, 1'b0);
    run_txn(1'b1, 7'h05, 32'h0, 32'hA1B2C3D4, 0, 1'b1);
    run_txn(1'b1, 7'h33, 32'h0, 32'h5A6B7C8D, 10, 1'b0);

    // start while spi_master is still in reset must be dropped
    clear_log();
    i_rst_busy = 1'b1; i_start = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    i_start = 1'b0; i_rst_busy = 1'b0;
    tick();
    chk("rst_busy_no_dv", 64'(dv_cnt), 64'd0);
    chk("rst_busy_idle", 64'(obs_busy), 64'd0);

    // byte-done never arrives: abort after TIMEOUT_CYCLES in WAIT_DONE
    flush();
    clear_log();
    stall = 1'b1;
    i_rw = 1'b1; i_addr = 7'h44; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n = 0;
    while (err_cnt == 0 && done_cnt == 0 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("timeout_bound", 64'd0, 64'd1);
    tick();
    stall = 1'b0;
    chk("to_err_pulses", 64'(err_cnt), 64'd1);
    chk("to_done_pulses", 64'(done_cnt), 64'd0);
    chk("to_dv_count", 64'(dv_cnt), 64'd1);
    chk("to_latency", 64'(err_cyc - dv_cyc), 64'(TIMEOUT_CYCLES + 1));
    chk("to_busy_at_err", 64'(busy_at_err), 64'd0);
    chk("to_busy_after", 64'(obs_busy), 64'd0);
    chk("to_rdata", 64'(obs_rdata), 64'(model_rdata));

    // reset while byte 2 is in flight
    flush();
    clear_log();
    for (int k = 0; k < N; k++) resp[k] = 8'($urandom);
    i_rw = 1'b0; i_addr = 7'h21; i_wdata = 32'h11223344; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n = 0;
    while (dv_cnt < 3 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("midrst_bound", 64'd0, 64'd1);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    tick();
    chk("midrst_busy", 64'(obs_busy), 64'd0);
    chk("midrst_dv", 64'(obs_dv), 64'd0);
    chk("midrst_re", 64'(obs_re), 64'd0);
    chk("midrst_tx", 64'(obs_tx), 64'd0);
    chk("midrst_done", 64'(done_cnt), 64'd0);
    chk("midrst_err", 64'(err_cnt), 64'd0);
    chk("midrst_rdata", 64'(obs_rdata), 64'd0);
    model_rdata = '0;
    run_txn(1'b0, 7'h7F, 32'hCAFE0123, 32'h0, 2, 1'b0);

    for (int t = 0; t < 16; t++) begin
      lat_max = $urandom_range(6, 1);
      run_txn(1'($urandom), 7'($urandom), W'($urandom), W'($urandom),
              $urandom_range(4, 0), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_txn_ctrl.md
Name: spi_txn_ctrl

Overview:
Register-access transaction controller that sits directly in front of spi_master on the same clock. It turns a single host request (read/write, 7-bit address, DATA_BYTES of data) into a byte stream on spi_master's TX input (i_DV/i_parallel_in). It also drains the matching received bytes from spi_master's RX FIFO (i_read_enable/o_fifo_out/o_rx_empty) and returns assembled read data to the host.

Parameters:
DATA_BYTES, 4, data bytes per transaction (1..8); rdata/wdata width = 8*DATA_BYTES
TIMEOUT_CYCLES, 4096, max i_clk cycles to wait for a byte-done or RX-not-empty before aborting
CNT_W, 13, width of the timeout counter (must hold TIMEOUT_CYCLES)

Ports:
i_clk  in  1  system clock, shared with spi_master
i_reset  in  1  synchronous, active-high reset
i_start  in  1  host request strobe, sampled in IDLE only
i_rw  in  1  1 = read, 0 = write
i_addr  in  7  register address
i_wdata  in  8*DATA_BYTES  write data, MSB byte sent first
o_busy  out  1  high from accepted start until o_done/o_error
o_done  out  1  one-cycle pulse, transaction completed
o_error  out  1  one-cycle pulse, transaction aborted by timeout
o_rdata  out  8*DATA_BYTES  read data, valid from o_done until next accepted start
o_DV  out  1  to spi_master i_DV, one-cycle byte push
o_tx_byte  out  8  to spi_master i_parallel_in
i_byte_done  in  1  from spi_master o_done, one-cycle pulse per completed byte
o_read_enable  out  1  to spi_master i_read_enable
i_rx_byte  in  8  from spi_master o_fifo_out
i_rx_empty  in  1  from spi_master o_rx_empty
i_rst_busy  in  1  from spi_master o_rst_busy

Behaviour:
- Reset (i_reset=1 at posedge): state=IDLE, all outputs 0, o_rdata=0, counters 0. Reset mid-transaction aborts with no o_done/o_error pulse. A byte already handed to spi_master is not recalled.
- Frame format: byte 0 = {i_rw, i_addr}. Bytes 1..DATA_BYTES: write = i_wdata from MSB byte downward; read = 0x00. Total N = DATA_BYTES+1.
- Start acceptance: in IDLE with i_start=1 and i_rst_busy=0. The controller latches rw/addr/wdata, asserts o_busy the next cycle, and goes to SEND. i_start during busy or during i_rst_busy is ignored (not queued).
- SEND: o_DV=1 for exactly one cycle with o_tx_byte = current byte, then WAIT_DONE. Only one byte is outstanding at a time.
- WAIT_DONE: on i_byte_done go to POP. Otherwise increment the timeout counter; at TIMEOUT_CYCLES go to ABORT.
- POP: wait for i_rx_empty=0 (same timeout rule). Then assert o_read_enable for one cycle and go to CAPTURE.
- CAPTURE: i_rx_byte is valid in this cycle (one cycle after o_read_enable). Byte 0 response is discarded. For reads, bytes 1..N-1 shift into o_rdata MSB-first. Writes discard all RX bytes. If the byte index is N-1, go to FINISH; else increment the index and go to SEND.
- FINISH: o_done=1 for one cycle, o_busy=0 in the same cycle, then IDLE.
- ABORT: o_error=1 for one cycle, o_busy=0, o_rdata unchanged, then IDLE.
- Timeout counter clears on every state change and saturates; it never wraps.
- i_byte_done seen outside WAIT_DONE is ignored.
- Per-byte minimum latency: SEND 1 + SPI byte time + POP 1 + CAPTURE 1 cycles.
- o_rdata is overwritten only in CAPTURE of read transactions.

Decomposition:
- Shared package spi_pkg holds the state encoding (IDLE, SEND, WAIT_DONE, POP, CAPTURE, FINISH, ABORT) and the frame constants (RW bit position, read dummy byte 0x00).
- One sub-module, spi_txn_timeout: a loadable saturating counter with clear, enable and expired outputs.

Test Plan:
- Write, addr 0x12, wdata 0xDEADBEEF, spi_master + spi_slave loopback -> slave receives 0x12, 0xDE, 0xAD, 0xBE, 0xEF; o_done one pulse; o_rdata stays 0.
- Read, addr 0x05, slave TX loaded with 0x00, 0xA1, 0xB2, 0xC3, 0xD4 -> first byte 0x85 on MOSI; o_rdata = 0xA1B2C3D4 at o_done.
- i_start pulsed again mid-transaction and while i_rst_busy=1 -> ignored; exactly one o_DV per frame byte; 5 o_DV pulses in total.
- i_byte_done stub tied 0, TIMEOUT_CYCLES=16 -> o_error pulses 16 cycles after WAIT_DONE entry; o_busy falls; o_rdata unchanged.
- i_reset=1 during byte 2 -> next cycle all outputs 0, state IDLE; a new write afterwards completes normally.
- i_rx_empty held 1 for 10 cycles after i_byte_done -> o_read_enable asserted only once it drops; captured byte correct.
